// File: rtl/system_servo_pwm.sv
// Four-channel servo PWM generator with an Avalon-style register file.
// A frame starts on frame_tick. All channels rise together and each falls after width_i prescaled ticks.
module system_servo_pwm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    input  logic        frame_tick,
    output logic [15:0] readdata,
    output logic [3:0]  pwm_out,
    output logic        frame_done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_enable;
    logic        r_overrun;
    logic [15:0] r_prescale;
    logic [15:0] r_width [4];
    logic [15:0] r_sh_prescale;
    logic [15:0] r_sh_width [4];
    logic [15:0] r_pcnt;
    logic [15:0] r_tcnt;
    logic        r_frame_done;
    logic [15:0] r_readdata;

    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_start;
    logic        w_end;
    logic        w_abort;
    logic [3:0]  w_pwm;
    logic [15:0] w_rdmux;

    assign w_wr      = chipselect && !write_n;
    assign w_wr_ctrl = w_wr && (address == 3'd0);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_pwm[i] = (r_state == ST_RUN) && (r_tcnt < r_sh_width[i]);
        end
    end

    // Enable is sampled from the register, so a tick coincident with the enabling write is ignored.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_end        = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_tick && r_enable) begin
                    w_start      = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_wr_ctrl && !writedata[0]) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_pwm == 4'b0000) begin
                    w_end        = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_frame_done <= w_end;
        end
    end

    // Control/status and the live register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable   <= 1'b0;
            r_overrun  <= 1'b0;
            r_prescale <= 16'd49;
            for (int i = 0; i < 4; i++) begin
                r_width[i] <= 16'd1500;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= writedata[0];
            end
            if (frame_tick && (r_state == ST_RUN)) begin
                r_overrun <= 1'b1;
            end else if (w_wr_ctrl && writedata[2]) begin
                r_overrun <= 1'b0;
            end
            if (w_wr) begin
                case (address)
                    3'd1:    r_prescale <= writedata;
                    3'd2:    r_width[0] <= writedata;
                    3'd3:    r_width[1] <= writedata;
                    3'd4:    r_width[2] <= writedata;
                    3'd5:    r_width[3] <= writedata;
                    default: ;
                endcase
            end
        end
    end

    // Shadows freeze the frame parameters so that mid-frame writes land on the next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_prescale <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                r_sh_width[i] <= 16'd0;
            end
            r_pcnt <= 16'd0;
            r_tcnt <= 16'd0;
        end else if (w_start) begin
            r_sh_prescale <= r_prescale;
            for (int i = 0; i < 4; i++) begin
                r_sh_width[i] <= r_width[i];
            end
            r_pcnt <= 16'd0;
            r_tcnt <= 16'd0;
        end else if (r_state == ST_RUN) begin
            if (r_pcnt == r_sh_prescale) begin
                r_pcnt <= 16'd0;
                if (r_tcnt != 16'hFFFF) begin
                    r_tcnt <= r_tcnt + 16'd1;
                end
            end else begin
                r_pcnt <= r_pcnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_rdmux = 16'd0;
        case (address)
            3'd0:    w_rdmux = {13'd0, r_overrun, (r_state == ST_RUN), r_enable};
            3'd1:    w_rdmux = r_prescale;
            3'd2:    w_rdmux = r_width[0];
            3'd3:    w_rdmux = r_width[1];
            3'd4:    w_rdmux = r_width[2];
            3'd5:    w_rdmux = r_width[3];
            3'd6:    w_rdmux = r_tcnt;
            default: w_rdmux = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 16'd0;
        end else begin
            r_readdata <= w_rdmux;
        end
    end

    assign readdata   = r_readdata;
    assign pwm_out    = w_pwm;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_system_servo_pwm.sv
// Directed bench for system_servo_pwm. Inputs are driven and outputs are sampled 1 ns after each rising edge.
// Frames are measured cycle by cycle, where cycle 0 is the first RUN cycle.
module tb_system_servo_pwm;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic        frame_tick;
    logic [15:0] readdata;
    logic [3:0]  pwm_out;
    logic        frame_done;

    int          n_vec;
    int          n_err;
    int          hi_cnt [4];
    int          done_cyc;
    int          fall0;
    int          done_cnt;
    logic [15:0] rd_snap;
    logic [3:0]  pwm_snap;

    system_servo_pwm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .frame_tick (frame_tick),
        .readdata   (readdata),
        .pwm_out    (pwm_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        address = a;
        cyc();
        check(tag, {16'd0, readdata}, {16'd0, exp});
        address = 3'd0;
    endtask

    task automatic start_frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    // Walk a frame from its first RUN cycle, optionally injecting one write and/or tick at ev_cyc.
    task automatic measure(input int budget, input int ev_cyc, input logic ev_wr,
                           input logic [2:0] ev_addr, input logic [15:0] ev_data,
                           input logic ev_tick);
        logic prev0;
        bit   stop;
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        done_cyc = -1;
        fall0    = -1;
        done_cnt = 0;
        prev0    = 1'b0;
        stop     = 1'b0;
        rd_snap  = '0;
        pwm_snap = '0;
        for (int c = 0; c < budget && !stop; c++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (pwm_out[ch]) hi_cnt[ch]++;
            end
            if (prev0 && !pwm_out[0] && fall0 < 0) fall0 = c;
            prev0 = pwm_out[0];
            if (c == ev_cyc + 1) pwm_snap = pwm_out;
            if (c == ev_cyc + 3) rd_snap = readdata;
            if (frame_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                stop = 1'b1;
            end
            if (c == ev_cyc) begin
                if (ev_wr) begin
                    chipselect = 1'b1;
                    write_n    = 1'b0;
                    address    = ev_addr;
                    writedata  = ev_data;
                end
                frame_tick = ev_tick;
            end else begin
                chipselect = 1'b0;
                write_n    = 1'b1;
                address    = 3'd0;
                frame_tick = 1'b0;
            end
            if (!stop) cyc();
        end
    endtask

    task automatic check_frame(input string tag, input int h0, input int h1, input int h2,
                               input int h3, input int dc);
        check({tag, "_hi0"}, hi_cnt[0], h0);
        check({tag, "_hi1"}, hi_cnt[1], h1);
        check({tag, "_hi2"}, hi_cnt[2], h2);
        check({tag, "_hi3"}, hi_cnt[3], h3);
        check({tag, "_done_cyc"}, done_cyc, dc);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'd0;
        frame_tick = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        // Reset values
        check("rst_pwm", {28'd0, pwm_out}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        rd(3'd0, 16'd0,    "rst_ctrl");
        rd(3'd1, 16'd49,   "rst_prescale");
        rd(3'd2, 16'd1500, "rst_width0");
        rd(3'd3, 16'd1500, "rst_width1");
        rd(3'd4, 16'd1500, "rst_width2");
        rd(3'd5, 16'd1500, "rst_width3");
        rd(3'd6, 16'd0,    "rst_count");
        rd(3'd7, 16'd0,    "rst_reserved");

        // Basic frame: prescale 1, widths 3,1,0,2 -> 6,2,0,4 clocks high
        wr(3'd1, 16'd1);
        wr(3'd2, 16'd3);
        wr(3'd3, 16'd1);
        wr(3'd4, 16'd0);
        wr(3'd5, 16'd2);
        wr(3'd7, 16'hFFFF);
        wr(3'd0, 16'd1);
        rd(3'd7, 16'd0, "reserved_ignored");
        start_frame();
        measure(40, -1, 1'b0, 3'd0, 16'd0, 1'b0);
        check_frame("basic", 6, 2, 0, 4, 7);
        check("basic_fall0", fall0, 6);
        cyc();
        check("basic_done_one_cycle", {31'd0, frame_done}, 32'd0);
        rd(3'd0, 16'd1, "basic_ctrl_idle");
        rd(3'd6, 16'd3, "basic_count_hold");

        // Shadowing: WIDTH0=10 mid-frame applies only to the next frame
        start_frame();
        measure(40, 2, 1'b1, 3'd2, 16'd10, 1'b0);
        check_frame("shadow_cur", 6, 2, 0, 4, 7);
        cyc();
        start_frame();
        measure(40, -1, 1'b0, 3'd0, 16'd0, 1'b0);
        check_frame("shadow_next", 20, 2, 0, 4, 21);
        cyc();

        // Overrun: tick during RUN leaves frame intact, CTRL reads 7 while busy
        start_frame();
        measure(40, 3, 1'b0, 3'd0, 16'd0, 1'b1);
        check_frame("ovr", 20, 2, 0, 4, 21);
        check("ovr_ctrl_busy", {16'd0, rd_snap}, 32'd7);
        rd(3'd0, 16'd5, "ovr_ctrl_idle");
        wr(3'd0, 16'd5);
        rd(3'd0, 16'd1, "ovr_cleared");

        // Overrun set and clear in the same cycle: set wins
        start_frame();
        measure(40, 3, 1'b1, 3'd0, 16'd5, 1'b1);
        check_frame("ovr_race", 20, 2, 0, 4, 21);
        rd(3'd0, 16'd5, "ovr_race_set_wins");
        wr(3'd0, 16'd5);
        rd(3'd0, 16'd1, "ovr_race_cleared");

        // Abort: CTRL=0 at cycle 4 -> outputs low next cycle, no frame_done
        start_frame();
        measure(30, 4, 1'b1, 3'd0, 16'd0, 1'b0);
        check("abort_hi0", hi_cnt[0], 5);
        check("abort_hi3", hi_cnt[3], 4);
        check("abort_pwm_next", {28'd0, pwm_snap}, 32'd0);
        check("abort_no_done", done_cnt, 0);
        rd(3'd0, 16'd0, "abort_ctrl");
        start_frame();
        check("disabled_tick_pwm", {28'd0, pwm_out}, 32'd0);
        rd(3'd0, 16'd0, "disabled_tick_no_ovr");

        // Tick coincident with the enabling write is ignored
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 16'd1;
        frame_tick = 1'b1;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        frame_tick = 1'b0;
        check("en_race_pwm", {28'd0, pwm_out}, 32'd0);
        rd(3'd0, 16'd1, "en_race_ctrl");

        // All widths zero, prescale 0: one RUN cycle then frame_done
        wr(3'd1, 16'd0);
        wr(3'd2, 16'd0);
        wr(3'd3, 16'd0);
        wr(3'd4, 16'd0);
        wr(3'd5, 16'd0);
        start_frame();
        measure(10, -1, 1'b0, 3'd0, 16'd0, 1'b0);
        check_frame("zero", 0, 0, 0, 0, 1);
        rd(3'd6, 16'd1, "zero_count");

        // Reset mid-frame
        wr(3'd1, 16'd1);
        wr(3'd2, 16'd5);
        start_frame();
        cyc();
        cyc();
        check("midrst_pre_pwm", {28'd0, pwm_out}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_pwm", {28'd0, pwm_out}, 32'd0);
        check("midrst_done", {31'd0, frame_done}, 32'd0);
        check("midrst_readdata", {16'd0, readdata}, 32'd0);
        cyc();
        reset_n = 1'b1;
        check("midrst_after_done", {31'd0, frame_done}, 32'd0);
        rd(3'd0, 16'd0,    "midrst_ctrl");
        rd(3'd1, 16'd49,   "midrst_prescale");
        rd(3'd2, 16'd1500, "midrst_width0");
        rd(3'd6, 16'd0,    "midrst_count");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
